// File: rtl/wb_hword_responder_pkg.sv
// wb_hword_responder_pkg: shared request-entry type and sizing helpers for the half-word responder
package wb_hword_responder_pkg;
  localparam int WAIT_W = 4;
  localparam int IDX_W_MAX = 16;
  typedef struct packed {
    logic [IDX_W_MAX-1:0] adr_idx;
    logic                 out_of_range;
    logic                 we;
    logic [15:0]          dat;
  } req_t;
  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_hword_responder_if.sv
// wb_hword_responder_if: 16-bit Wishbone slave bus between the LSU and the half-word responder
interface wb_hword_responder_if;
  logic [63:0] wbsadr_i;
  logic [15:0] wbsdat_i;
  logic        wbswe_i;
  logic        wbsstb_i;
  logic        wbsstall_o;
  logic        wbsack_o;
  logic        wbserr_o;
  logic [15:0] wbsdat_o;
  modport slave (
    input  wbsadr_i, wbsdat_i, wbswe_i, wbsstb_i,
    output wbsstall_o, wbsack_o, wbserr_o, wbsdat_o
  );
  modport master (
    output wbsadr_i, wbsdat_i, wbswe_i, wbsstb_i,
    input  wbsstall_o, wbsack_o, wbserr_o, wbsdat_o
  );
endinterface

// File: rtl/wb_req_fifo.sv
// wb_req_fifo: circular request queue; pointers carry an extra wrap bit to tell full from empty
module wb_req_fifo
  import wb_hword_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push,
  input  logic          pop,
  input  req_t          din,
  output req_t          dout,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);
  req_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign count = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr[PW-2:0]];
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr[PW-2:0]] <= din;
endmodule

// File: rtl/wb_hword_responder.sv
// wb_hword_responder: queued Wishbone half-word memory slave with programmable wait states
module wb_hword_responder
  import wb_hword_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 4,
  parameter int WAIT = 1
) (
  input logic                 clk_i,
  input logic                 reset_i,
  wb_hword_responder_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  req_t push_req, head;
  logic full, empty, service;
  logic [PW-1:0] count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] idx;
  logic [15:0] mem [2**ADDR_W];
  assign bus.wbsstall_o = count == PW'(DEPTH);
  assign push_req = '{
    adr_idx:      IDX_W_MAX'(bus.wbsadr_i[ADDR_W:1]),
    out_of_range: |(bus.wbsadr_i >> (ADDR_W + 1)),
    we:           bus.wbswe_i,
    dat:          bus.wbsdat_i
  };
  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (bus.wbsstb_i & ~full),
    .pop     (service),
    .din     (push_req),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  assign idx = head.adr_idx[ADDR_W-1:0];
  assign service = ~empty && wait_cnt == '0;
  // reading mem here sees the pre-write value, giving read-before-write on writes
  always_ff @(posedge clk_i)
    if (reset_i) begin
      wait_cnt <= WAIT_W'(WAIT);
      bus.wbsack_o <= 1'b0;
      bus.wbserr_o <= 1'b0;
      bus.wbsdat_o <= '0;
    end else begin
      bus.wbsack_o <= service & ~head.out_of_range;
      bus.wbserr_o <= service & head.out_of_range;
      if (service) bus.wbsdat_o <= head.out_of_range ? '0 : mem[idx];
      wait_cnt <= service ? WAIT_W'(WAIT) : (empty ? wait_cnt : wait_cnt - 1'b1);
    end
  always_ff @(posedge clk_i)
    if (service & ~head.out_of_range & head.we) mem[idx] <= head.dat;
endmodule

// File: tb/tb_wb_hword_responder.sv
// tb_wb_hword_responder: scoreboard bench driving a WAIT=1 and a WAIT=3 responder against a queue/map model
module tb_wb_hword_responder;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 4;
  localparam int W [2] = '{1, 3};

  typedef struct {
    bit          err;
    bit          known;
    logic [15:0] dat;
    bit          we;
    int          key;
    logic [15:0] wd;
    int          cyc;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic [63:0] adr [2];
  logic [15:0] wdat [2];
  logic we_s [2];
  logic stb [2];
  logic ack [2], err [2], stall [2];
  logic [15:0] rdat [2];

  int cyc = 0;
  int ncmp = 0, nfail = 0;
  exp_t exq [2][$];
  logic [15:0] spec_mem [int];
  logic [15:0] commit_mem [int];
  int last_s [2];
  bit last_known [2];
  logic [15:0] last_dat [2];
  int acks [2];

  wb_hword_responder_if bus0 ();
  wb_hword_responder_if bus1 ();

  wb_hword_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT(1)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .bus(bus0.slave));
  wb_hword_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT(3)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .bus(bus1.slave));

  assign bus0.wbsadr_i = adr[0];
  assign bus0.wbsdat_i = wdat[0];
  assign bus0.wbswe_i = we_s[0];
  assign bus0.wbsstb_i = stb[0];
  assign bus1.wbsadr_i = adr[1];
  assign bus1.wbsdat_i = wdat[1];
  assign bus1.wbswe_i = we_s[1];
  assign bus1.wbsstb_i = stb[1];
  assign ack[0] = bus0.wbsack_o;
  assign err[0] = bus0.wbserr_o;
  assign stall[0] = bus0.wbsstall_o;
  assign rdat[0] = bus0.wbsdat_o;
  assign ack[1] = bus1.wbsack_o;
  assign err[1] = bus1.wbserr_o;
  assign stall[1] = bus1.wbsstall_o;
  assign rdat[1] = bus1.wbsdat_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reset discards everything still queued, so uncommitted writes are forgotten
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        exq[i].delete();
        last_s[i] = 0;
        last_known[i] = 1;
        last_dat[i] = 16'h0;
      end
      spec_mem = commit_mem;
    end

  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 2; i++) begin
        if (ack[i] || err[i]) begin
          ncmp++;
          if (exq[i].size() == 0) begin
            nfail++;
            $display("FAIL spurious_resp dut%0d cyc=%0d ack=%b err=%b", i, cyc, ack[i], err[i]);
          end else begin
            exp_t e;
            e = exq[i].pop_front();
            if (ack[i] !== !e.err || err[i] !== e.err || cyc != e.cyc ||
                (e.known && rdat[i] !== e.dat)) begin
              nfail++;
              $display("FAIL response dut%0d: got ack=%b err=%b dat=%h cyc=%0d, want ack=%b err=%b dat=%h cyc=%0d",
                       i, ack[i], err[i], rdat[i], cyc, !e.err, e.err, e.dat, e.cyc);
            end
            if (e.we) commit_mem[e.key] = e.wd;
            last_known[i] = e.known;
            last_dat[i] = e.dat;
            acks[i]++;
          end
        end else begin
          if (exq[i].size() > 0 && exq[i][0].cyc <= cyc) begin
            ncmp++;
            nfail++;
            $display("FAIL missing_resp dut%0d: none at cyc=%0d, want one at cyc=%0d", i, cyc, exq[i][0].cyc);
            void'(exq[i].pop_front());
          end
          if (last_known[i]) begin
            ncmp++;
            if (rdat[i] !== last_dat[i]) begin
              nfail++;
              $display("FAIL idle_hold dut%0d: dat=%h want %h", i, rdat[i], last_dat[i]);
            end
          end
        end
      end

  // called at a negedge; returns at the negedge after the request is accepted
  task automatic issue(input int i, input logic [63:0] a, input bit w, input logic [15:0] d);
    bit acc = 0;
    int tries = 0;
    adr[i] = a;
    wdat[i] = d;
    we_s[i] = w;
    stb[i] = 1;
    while (!acc) begin
      bit exp_stall;
      #4;
      exp_stall = exq[i].size() == DEPTH;
      ncmp++;
      if (stall[i] !== exp_stall) begin
        nfail++;
        $display("FAIL stall dut%0d cyc=%0d: got %b want %b", i, cyc, stall[i], exp_stall);
      end
      acc = !stall[i];
      if (acc) begin
        exp_t e;
        int idx, k, start;
        bit oor;
        idx = int'(a[ADDR_W:1]);
        oor = (a >> (ADDR_W + 1)) != 0;
        k = i * 65536 + idx;
        start = (cyc + 1 > last_s[i]) ? cyc + 1 : last_s[i];
        e.cyc = start + W[i] + 1;
        last_s[i] = e.cyc;
        e.err = oor;
        e.key = k;
        e.wd = d;
        e.we = w && !oor;
        e.known = oor || spec_mem.exists(k);
        e.dat = (!oor && spec_mem.exists(k)) ? spec_mem[k] : 16'h0;
        if (e.we) spec_mem[k] = d;
        exq[i].push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      if (++tries > 60 && !acc) begin
        ncmp++;
        nfail++;
        $display("FAIL accept_timeout dut%0d", i);
        acc = 1;
      end
    end
    stb[i] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exq[0].size() != 0 || exq[1].size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exq[0].size() != 0 || exq[1].size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL drain_timeout pending=%0d/%0d", exq[0].size(), exq[1].size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst <= 1;
    @(negedge clk);
    rst <= 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      stb[i] = 0; we_s[i] = 0; adr[i] = '0; wdat[i] = '0; acks[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst <= 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ncmp++;
      if (ack[i] !== 0 || err[i] !== 0 || rdat[i] !== 0 || stall[i] !== 0) begin
        nfail++;
        $display("FAIL reset_state dut%0d: ack=%b err=%b dat=%h stall=%b", i, ack[i], err[i], rdat[i], stall[i]);
      end
    end
    issue(0, 64'h788, 1, 16'hDEAD);
    drain();
    issue(0, 64'h788, 0, 16'h0);
    drain();
    issue(0, 64'h78A, 1, 16'h3322);
    issue(0, 64'h788, 1, 16'h1100);
    issue(0, 64'h78A, 0, 16'h0);
    issue(0, 64'h788, 0, 16'h0);
    drain();
    issue(0, 64'h1122334455667788, 0, 16'h0);
    issue(0, 64'h1122334455667788, 1, 16'hBEEF);
    issue(0, 64'h788, 0, 16'h0);
    drain();
    issue(0, 64'h10, 1, 16'hBEEF);
    issue(0, 64'h10, 0, 16'h0);
    drain();
    for (int k = 0; k < 6; k++) issue(1, 64'h200 + 64'(2 * k), 1, 16'(16'hA000 + k));
    drain();
    ncmp++;
    if (acks[1] != 6) begin
      nfail++;
      $display("FAIL full_ack_count got %0d want 6", acks[1]);
    end
    for (int k = 0; k < 6; k++) issue(1, 64'h200 + 64'(2 * k), 0, 16'h0);
    drain();
    issue(0, 64'h20, 1, 16'h1111);
    issue(0, 64'h22, 1, 16'h2222);
    drain();
    issue(0, 64'h20, 1, 16'h5555);
    issue(0, 64'h22, 1, 16'h6666);
    issue(0, 64'h24, 1, 16'h7777);
    pulse_reset();
    ncmp++;
    if (stall[0] !== 0 || ack[0] !== 0 || err[0] !== 0) begin
      nfail++;
      $display("FAIL post_reset stall=%b ack=%b err=%b", stall[0], ack[0], err[0]);
    end
    repeat (6) @(negedge clk);
    issue(0, 64'h20, 0, 16'h0);
    issue(0, 64'h22, 0, 16'h0);
    issue(0, 64'h788, 0, 16'h0);
    drain();
    for (int n = 0; n < 250; n++) begin
      int i;
      logic [63:0] a;
      i = int'($urandom_range(1, 0));
      a = {49'h0, 4'($urandom_range(15, 0)), 11'($urandom_range(31, 0))};
      if ($urandom_range(7, 0) == 0) a = {$urandom, $urandom};
      issue(i, a, 1'($urandom_range(1, 0)), 16'($urandom));
      if ($urandom_range(3, 0) == 0) @(negedge clk);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
